// File: rtl/video_fetch.sv
// Video-side read initiator: walks a 1bpp bitmap line by line through a small
// prefetch FIFO and serialises each byte MSB-first, one pixel per pix_en strobe.
module video_fetch #(
  parameter int BYTES_PER_LINE = 40,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_en,
  input  logic [15:0] base,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        pixel,
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  BPL8  = 8'(BYTES_PER_LINE);
  localparam logic [15:0] BPL16 = 16'(BYTES_PER_LINE);

  logic [15:0]   next_line_q, next_line_d;
  logic [15:0]   fetch_addr_q, fetch_addr_d;
  logic [7:0]    fetch_left_q, fetch_left_d;
  logic [7:0]    consume_left_q, consume_left_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bits_left_q, bits_left_d;
  logic          pixel_q, pixel_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic       issue;
  logic       pop;
  logic [7:0] head;
  logic [15:0] line_addr;

  // A read is only issued when the FIFO can absorb it on arrival, so it never overflows.
  assign issue = rst_n && !line_start && (fetch_left_q != 8'd0) &&
                 ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
  assign pop   = pix_en && !line_start && (bits_left_q == 3'd0) && (count_q != '0);
  assign head  = fifo_q[rd_ptr_q];
  assign line_addr = frame_start ? base : next_line_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
    next_line_d    = next_line_q;
    fetch_addr_d   = fetch_addr_q;
    fetch_left_d   = fetch_left_q;
    consume_left_d = consume_left_q;
    inflight_d     = inflight_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    sh_d           = sh_q;
    bits_left_d    = bits_left_q;
    pixel_d        = pixel_q;
    underrun_d     = 1'b0;

    if (frame_start) next_line_d = base;

    if (line_start) begin
      // New line: flush everything, including a read whose data is still on its way.
      fetch_addr_d   = line_addr;
      next_line_d    = line_addr + BPL16;
      fetch_left_d   = BPL8;
      consume_left_d = BPL8;
      inflight_d     = 1'b0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      sh_d           = 8'd0;
      bits_left_d    = 3'd0;
      pixel_d        = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_addr_d = fetch_addr_q + 16'd1;
        fetch_left_d = fetch_left_q - 8'd1;
      end
      if (inflight_q) wr_ptr_d = wr_ptr_q + AW'(1);

      if (pix_en) begin
        if (bits_left_q != 3'd0) begin
          pixel_d     = sh_q[7];
          sh_d        = {sh_q[6:0], 1'b0};
          bits_left_d = bits_left_q - 3'd1;
        end else if (count_q != '0) begin
          pixel_d        = head[7];
          sh_d           = {head[6:0], 1'b0};
          bits_left_d    = 3'd7;
          consume_left_d = consume_left_q - 8'd1;
          rd_ptr_d       = rd_ptr_q + AW'(1);
        end else begin
          // Empty FIFO: starved mid-line raises underrun, past end of line it is border.
          pixel_d    = 1'b0;
          underrun_d = (consume_left_q != 8'd0);
        end
      end
      count_d = count_q + CW'(inflight_q) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst_n) begin
      next_line_q    <= 16'd0;
      fetch_addr_q   <= 16'd0;
      fetch_left_q   <= 8'd0;
      consume_left_q <= 8'd0;
      inflight_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      sh_q           <= 8'd0;
      bits_left_q    <= 3'd0;
      pixel_q        <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      next_line_q    <= next_line_d;
      fetch_addr_q   <= fetch_addr_d;
      fetch_left_q   <= fetch_left_d;
      consume_left_q <= consume_left_d;
      inflight_q     <= inflight_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      sh_q           <= sh_d;
      bits_left_q    <= bits_left_d;
      pixel_q        <= pixel_d;
      underrun_q     <= underrun_d;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= mem_data;
  end

  assign mem_en   = issue;
  assign mem_addr = fetch_addr_q;
  assign pixel    = pixel_q;
  assign underrun = underrun_q;

endmodule
